// File: rtl/id_stream_tx.sv
`default_nettype none
// ============================================================================
// Module   : id_stream_tx
// Brief    : Character-stream transmitter feeding the identifier recognizer.
//            Buffers host-written {last, char} pairs in a 2**AW-deep FIFO and
//            drives them out one per clock over a valid/ready handshake.
//            Define ID_TX_DELIM_EN to append a DELIM beat after every token.
// Revision : 1.0 - initial release
// ============================================================================
module id_stream_tx #(
  parameter int unsigned AW    = 3,
  parameter logic [7:0]  DELIM = 8'h20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          wr_last,
  output logic          full,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic [7:0]    char,
  output logic          char_valid,
  input  logic          char_ready,
  output logic          tok_done
);

  localparam int unsigned c_DEPTH = 2 ** AW;

`ifdef ID_TX_DELIM_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_DELIM = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1
  } state_t;
`endif

  // FIFO storage and pointers (extra MSB separates full from empty)
  logic [8:0]  r_mem [c_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;

  // Output register
  logic [7:0]  r_char;
  logic        r_valid;
  logic        r_last;
  logic        r_tok;
  logic        r_ovf;
  state_t      r_state;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_xfer;
  logic [8:0]  w_head;
  state_t      w_state_nxt;
  logic        w_adv;
  logic        w_pop;
  logic        w_clr;
  logic        w_ld_delim;
  logic        w_tok;

  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty = (r_wptr == r_rptr);
  assign w_push  = wr_en && !w_full;
  assign w_xfer  = r_valid && char_ready;
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  assign full       = w_full;
  assign count      = r_wptr - r_rptr;
  assign ovf        = r_ovf;
  assign char       = r_char;
  assign char_valid = r_valid;
  assign tok_done   = r_tok;

  // FIFO storage write; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= {wr_last, wr_data};
    end
  end

  // FIFO pointers and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (AW+1)'(1);
      end
      if (wr_en && w_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: decide whether to fetch the next head, insert a
  // delimiter, or empty the output register
  always_comb begin
    w_state_nxt = r_state;
    w_adv       = 1'b0;
    w_pop       = 1'b0;
    w_clr       = 1'b0;
    w_ld_delim  = 1'b0;
    w_tok       = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Output register is already empty here; fetch as soon as data exists
        w_adv = 1'b1;
      end
      S_SEND: begin
        if (!r_valid || w_xfer) begin
          if (w_xfer && r_last) begin
`ifdef ID_TX_DELIM_EN
            w_ld_delim  = 1'b1;
            w_state_nxt = S_DELIM;
`else
            w_tok = 1'b1;
            w_adv = 1'b1;
`endif
          end else begin
            w_adv = 1'b1;
          end
        end
      end
`ifdef ID_TX_DELIM_EN
      S_DELIM: begin
        if (w_xfer) begin
          w_tok = 1'b1;
          w_adv = 1'b1;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // Advancing either loads the next head or drops char_valid
    if (w_adv) begin
      if (!w_empty) begin
        w_pop       = 1'b1;
        w_state_nxt = S_SEND;
      end else begin
        w_clr       = 1'b1;
        w_state_nxt = S_IDLE;
      end
    end
  end

  // Output register and token-done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_char  <= 8'h00;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_tok   <= 1'b0;
    end else begin
      r_tok <= w_tok;
      if (w_pop) begin
        r_char  <= w_head[7:0];
        r_last  <= w_head[8];
        r_valid <= 1'b1;
      end else if (w_ld_delim) begin
        r_char  <= DELIM;
        r_last  <= 1'b0;
        r_valid <= 1'b1;
      end else if (w_clr) begin
        r_char  <= 8'h00;
        r_last  <= 1'b0;
        r_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_stream_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stream_tx
// Brief    : Self-checking bench for id_stream_tx. A queue of expected output
//            beats is filled from accepted host writes and drained on every
//            observed handshake; directed steps cover latency, overflow,
//            back-pressure, push/pop balance and mid-stream reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_stream_tx;

`ifdef ID_TX_DELIM_EN
  localparam bit DELIM_ON = 1'b1;
`else
  localparam bit DELIM_ON = 1'b0;
`endif
  localparam logic [7:0] EXP_DELIM = 8'h20;

  typedef struct packed {
    logic [7:0] d;
    logic       fin;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_last;
  logic       full;
  logic [3:0] count;
  logic       ovf;
  logic [7:0] char;
  logic       char_valid;
  logic       char_ready;
  logic       tok_done;

  int    checks   = 0;
  int    failures = 0;
  int    n_xfer   = 0;
  logic  exp_ovf  = 1'b0;
  beat_t q[$];

  always #5 clk = ~clk;

  id_stream_tx #(.AW(3), .DELIM(8'h20)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .full       (full),
    .count      (count),
    .ovf        (ovf),
    .char       (char),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .tok_done   (tok_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: model the edge from the pre-edge view, then check post-edge
  task automatic cycle();
    logic       pv, pr, pw, pf, pl, exp_tok;
    logic [7:0] pc, pd;
    beat_t      b;
    pv = char_valid; pr = char_ready; pc = char;
    pw = wr_en; pf = full; pd = wr_data; pl = wr_last;
    exp_tok = 1'b0;
    if (pv && pr) begin
      n_xfer++;
      checks++;
      assert (q.size() != 0) else begin
        failures++;
        $error("FAIL xfer_extra observed=0x%0h expected=no_beat", pc);
      end
      if (q.size() != 0) begin
        b = q.pop_front();
        chk("xfer_char", {24'h0, pc}, {24'h0, b.d});
        exp_tok = b.fin;
      end
    end
    if (pw && !pf) begin
      q.push_back('{d: pd, fin: pl && !DELIM_ON});
      if (DELIM_ON && pl) q.push_back('{d: EXP_DELIM, fin: 1'b1});
    end
    if (pw && pf) exp_ovf = 1'b1;
    @(posedge clk); #1;
    chk("tok_done", {31'h0, tok_done}, {31'h0, exp_tok});
    chk("ovf", {31'h0, ovf}, {31'h0, exp_ovf});
    if (pv && !pr) begin
      chk("hold_valid", {31'h0, char_valid}, 32'h1);
      chk("hold_char", {24'h0, char}, {24'h0, pc});
    end
    if (!char_valid) chk("idle_char", {24'h0, char}, 32'h0);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    wr_en = 1'b0; wr_last = 1'b0; char_ready = 1'b1;
    while ((q.size() != 0 || char_valid) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_done", {31'h0, (q.size() == 0 && !char_valid)}, 32'h1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_char"}, {24'h0, char}, 32'h0);
    chk({tag, "_valid"}, {31'h0, char_valid}, 32'h0);
    chk({tag, "_full"}, {31'h0, full}, 32'h0);
    chk({tag, "_count"}, {28'h0, count}, 32'h0);
    chk({tag, "_ovf"}, {31'h0, ovf}, 32'h0);
    chk({tag, "_tok"}, {31'h0, tok_done}, 32'h0);
  endtask

  // Asynchronous reset mid-cycle; released one edge later
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    wr_en = 1'b0; wr_last = 1'b0;
    #1;
    check_reset_values(tag);
    q.delete();
    exp_ovf = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic put(input logic en, input logic [7:0] d, input logic last);
    wr_en = en; wr_data = d; wr_last = last;
  endtask

  initial begin
    int x0;
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; wr_last = 1'b0; char_ready = 1'b1;
    #12;
    check_reset_values("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic token "ab1"
    char_ready = 1'b1;
    put(1'b1, 8'h61, 1'b0); cycle();
    chk("latency_valid0", {31'h0, char_valid}, 32'h0);
    put(1'b1, 8'h62, 1'b0); cycle();
    chk("basic_c0", {23'h0, char_valid, char}, 32'h161);
    put(1'b1, 8'h31, 1'b1); cycle();
    chk("basic_c1", {23'h0, char_valid, char}, 32'h162);
    put(1'b0, 8'h00, 1'b0); cycle();
    chk("basic_c2", {23'h0, char_valid, char}, 32'h131);
    cycle();
    if (DELIM_ON) begin
      chk("basic_delim", {23'h0, char_valid, char}, {23'h0, 1'b1, EXP_DELIM});
      cycle();
    end
    chk("basic_end", {23'h0, char_valid, char}, 32'h0);
    cycle();
    chk("basic_quiet", {31'h0, tok_done}, 32'h0);

    // Overflow: 10 writes against a stalled consumer
    char_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      put(1'b1, 8'h41 + 8'(i), i == 9);
      cycle();
      if (i == 8) begin
        chk("ovf_count8", {28'h0, count}, 32'h8);
        chk("ovf_full", {31'h0, full}, 32'h1);
      end
    end
    chk("ovf_set", {31'h0, ovf}, 32'h1);
    x0 = n_xfer;
    drain(100);
    chk("ovf_emerged", n_xfer - x0, 32'd9);
    chk("ovf_sticky", {31'h0, ovf}, 32'h1);
    do_reset("ovf_clear");

    // Back-pressure: 4-char token with ready toggling every cycle
    char_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put(1'b1, 8'h70 + 8'(i), i == 3);
      cycle();
      char_ready = ~char_ready;
    end
    put(1'b0, 8'h00, 1'b0);
    for (int n = 0; n < 40 && (q.size() != 0 || char_valid); n++) begin
      cycle();
      char_ready = ~char_ready;
    end
    chk("bp_done", {31'h0, (q.size() == 0 && !char_valid)}, 32'h1);

    // Simultaneous push/pop at count 4
    char_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      put(1'b1, 8'h80 + 8'(i), 1'b0);
      cycle();
    end
    chk("pp_count_pre", {28'h0, count}, 32'h4);
    char_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put(1'b1, 8'h90 + 8'(i), i == 2);
      cycle();
      chk("pp_count_hold", {28'h0, count}, 32'h4);
    end
    drain(100);

    // Reset mid-token with three chars buffered
    char_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put(1'b1, 8'hA0 + 8'(i), 1'b0);
      cycle();
    end
    chk("mid_valid", {31'h0, char_valid}, 32'h1);
    chk("mid_count3", {28'h0, count}, 32'h3);
    do_reset("mid_reset");
    char_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("mid_no_stale", {31'h0, char_valid}, 32'h0);
    end

    // Randomized traffic against the beat queue
    for (int i = 0; i < 400; i++) begin
      put($urandom_range(0, 3) != 0, 8'($urandom_range(33, 126)), $urandom_range(0, 3) == 0);
      char_ready = (i % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      cycle();
    end
    drain(200);
    chk("final_queue_empty", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
